// File: rtl/fetch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// fetch_hazard_ctrl : fetch/decode/execute hazard sequencing + stall counter
// Revision: 1.0
// ============================================================================
module fetch_hazard_ctrl #(
  parameter int DWIDTH     = 32,
  parameter int MULDIV_LAT = 33,
  parameter int PERF_W     = 32
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core_N,
  input  logic [4:0]        rs1_addr_di,
  input  logic [4:0]        rs2_addr_di,
  input  logic              rs1_used_di,
  input  logic              rs2_used_di,
  input  logic [4:0]        rd_addr_ei,
  input  logic              mem_read_ei,
  input  logic              branch_taken_ei,
  input  logic [DWIDTH-1:0] branch_target_ei,
  input  logic              muldiv_start_ei,
  output logic              pc_sel_fi,
  output logic [DWIDTH-1:0] pc_imm_fi,
  output logic              stall_fi,
  output logic              flush_fi,
  output logic              stall_do,
  output logic              bubble_eo,
  output logic              hold_eo,
  output logic              muldiv_done_o,
  output logic [PERF_W-1:0] stall_cycles_o
);

  localparam int CNT_W = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [CNT_W-1:0] c_md_load = CNT_W'(MULDIV_LAT - 2);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_REDIRECT = 2'd1,
    S_MD_BUSY  = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_busy_cnt, w_busy_cnt_nxt;
  logic [PERF_W-1:0] r_stall_cycles;
  logic              r_muldiv_done, w_done_nxt;
  logic              w_lu;
  logic              w_pc_sel, w_stall_f, w_flush, w_stall_d, w_bubble, w_hold;
  logic [DWIDTH-1:0] w_pc_imm;

  assign w_lu = mem_read_ei && (rd_addr_ei != 5'd0) &&
                ((rs1_used_di && (rs1_addr_di == rd_addr_ei)) ||
                 (rs2_used_di && (rs2_addr_di == rd_addr_ei)));

  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      r_state       <= S_RUN;
      r_busy_cnt    <= '0;
      r_muldiv_done <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_busy_cnt    <= w_busy_cnt_nxt;
      r_muldiv_done <= w_done_nxt;
    end
  end

  // Priority in RUN: redirect, then MUL/DIV start, then load-use.
  always_comb begin
    w_state_nxt    = r_state;
    w_busy_cnt_nxt = r_busy_cnt;
    w_done_nxt     = 1'b0;
    w_pc_sel       = 1'b0;
    w_pc_imm       = '0;
    w_stall_f      = 1'b0;
    w_flush        = 1'b0;
    w_stall_d      = 1'b0;
    w_bubble       = 1'b0;
    w_hold         = 1'b0;
    case (r_state)
      S_RUN: begin
        if (branch_taken_ei) begin
          w_pc_sel    = 1'b1;
          w_pc_imm    = branch_target_ei;
          w_flush     = 1'b1;
          w_bubble    = 1'b1;
          w_state_nxt = S_REDIRECT;
        end else if (muldiv_start_ei) begin
          w_busy_cnt_nxt = c_md_load;
          w_state_nxt    = S_MD_BUSY;
        end else if (w_lu) begin
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_bubble  = 1'b1;
        end
      end
      S_REDIRECT: begin
        // Kills the wrong-path word from the synchronous instruction read.
        w_flush     = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_MD_BUSY: begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_hold    = 1'b1;
        if (r_busy_cnt == '0) begin
          w_state_nxt = S_RUN;
          w_done_nxt  = 1'b1;
        end else begin
          w_busy_cnt_nxt = r_busy_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Combinational controls are forced low for as long as reset is held.
  assign pc_sel_fi = Rst_Core_N & w_pc_sel;
  assign pc_imm_fi = Rst_Core_N ? w_pc_imm : '0;
  assign stall_fi  = Rst_Core_N & w_stall_f;
  assign flush_fi  = Rst_Core_N & w_flush;
  assign stall_do  = Rst_Core_N & w_stall_d;
  assign bubble_eo = Rst_Core_N & w_bubble;
  assign hold_eo   = Rst_Core_N & w_hold;

  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      r_stall_cycles <= '0;
    end else if (stall_fi && (r_stall_cycles != {PERF_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + PERF_W'(1);
    end
  end

  assign muldiv_done_o  = r_muldiv_done;
  assign stall_cycles_o = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_fetch_hazard_ctrl.sv
`default_nettype none
// Directed table-driven bench for fetch_hazard_ctrl, plus multi-cycle sequences.
module tb_fetch_hazard_ctrl;

  logic        Clk_Core = 1'b0;
  logic        Rst_Core_N = 1'b0;
  logic [4:0]  rs1_addr_di = '0, rs2_addr_di = '0, rd_addr_ei = '0;
  logic        rs1_used_di = 1'b0, rs2_used_di = 1'b0, mem_read_ei = 1'b0;
  logic        branch_taken_ei = 1'b0, muldiv_start_ei = 1'b0;
  logic [31:0] branch_target_ei = '0;

  logic        pc_sel_fi, stall_fi, flush_fi, stall_do, bubble_eo, hold_eo, muldiv_done_o;
  logic [31:0] pc_imm_fi, stall_cycles_o;
  logic        p4_pc_sel, p4_stall_f, p4_flush, p4_stall_d, p4_bubble, p4_hold, p4_done;
  logic [31:0] p4_pc_imm;
  logic [3:0]  p4_stall_cycles;

  fetch_hazard_ctrl #(.DWIDTH(32), .MULDIV_LAT(33), .PERF_W(32)) dut (
    .Clk_Core(Clk_Core), .Rst_Core_N(Rst_Core_N),
    .rs1_addr_di(rs1_addr_di), .rs2_addr_di(rs2_addr_di),
    .rs1_used_di(rs1_used_di), .rs2_used_di(rs2_used_di),
    .rd_addr_ei(rd_addr_ei), .mem_read_ei(mem_read_ei),
    .branch_taken_ei(branch_taken_ei), .branch_target_ei(branch_target_ei),
    .muldiv_start_ei(muldiv_start_ei),
    .pc_sel_fi(pc_sel_fi), .pc_imm_fi(pc_imm_fi), .stall_fi(stall_fi),
    .flush_fi(flush_fi), .stall_do(stall_do), .bubble_eo(bubble_eo),
    .hold_eo(hold_eo), .muldiv_done_o(muldiv_done_o), .stall_cycles_o(stall_cycles_o)
  );

  fetch_hazard_ctrl #(.DWIDTH(32), .MULDIV_LAT(33), .PERF_W(4)) dut_p4 (
    .Clk_Core(Clk_Core), .Rst_Core_N(Rst_Core_N),
    .rs1_addr_di(rs1_addr_di), .rs2_addr_di(rs2_addr_di),
    .rs1_used_di(rs1_used_di), .rs2_used_di(rs2_used_di),
    .rd_addr_ei(rd_addr_ei), .mem_read_ei(mem_read_ei),
    .branch_taken_ei(branch_taken_ei), .branch_target_ei(branch_target_ei),
    .muldiv_start_ei(muldiv_start_ei),
    .pc_sel_fi(p4_pc_sel), .pc_imm_fi(p4_pc_imm), .stall_fi(p4_stall_f),
    .flush_fi(p4_flush), .stall_do(p4_stall_d), .bubble_eo(p4_bubble),
    .hold_eo(p4_hold), .muldiv_done_o(p4_done), .stall_cycles_o(p4_stall_cycles)
  );

  always #5 Clk_Core = ~Clk_Core;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        rs1u, rs2u, memr, br, md;
    logic [31:0] tgt;
    logic        e_pc_sel;
    logic [31:0] e_pc_imm;
    logic        e_stall, e_flush, e_bubble, e_nxt_flush;
  } vec_t;

  vec_t vecs[9];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_perf = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk_Core);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic rs1u,
                       input logic rs2u, input logic [4:0] rd, input logic memr,
                       input logic br, input logic [31:0] tgt, input logic md);
    rs1_addr_di = rs1; rs2_addr_di = rs2; rs1_used_di = rs1u; rs2_used_di = rs2u;
    rd_addr_ei = rd; mem_read_ei = memr; branch_taken_ei = br;
    branch_target_ei = tgt; muldiv_start_ei = md;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic perf_chk(input string name);
    chk({name, "_perf"}, {32'd0, stall_cycles_o}, exp_perf);
    chk({name, "_perf4"}, {60'd0, p4_stall_cycles}, (exp_perf > 15) ? 15 : exp_perf);
  endtask

  initial begin
    //           rs1   rs2   rd    rs1u rs2u memr br   md   tgt           pcsel imm          stall flush bub  nxtfl
    vecs[0] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{5'd1, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{5'd3, 5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100,      1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEC, 1'b1, 32'hDEADBEEC, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state, with a branch request that must be masked.
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 32'h1234, 1'b0);
    tick(); tick();
    chk("rst_pc_sel", {63'd0, pc_sel_fi}, 0);
    chk("rst_pc_imm", {32'd0, pc_imm_fi}, 0);
    chk("rst_flush", {63'd0, flush_fi}, 0);
    chk("rst_stall", {63'd0, stall_fi}, 0);
    chk("rst_bubble", {63'd0, bubble_eo}, 0);
    perf_chk("rst");
    idle();
    Rst_Core_N = 1'b1;
    tick();

    // Single-cycle table; each vector is followed by one idle cycle.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rs1u, vecs[i].rs2u, vecs[i].rd,
            vecs[i].memr, vecs[i].br, vecs[i].tgt, vecs[i].md);
      #3;
      chk($sformatf("v%0d_pc_sel", i), {63'd0, pc_sel_fi}, {63'd0, vecs[i].e_pc_sel});
      chk($sformatf("v%0d_pc_imm", i), {32'd0, pc_imm_fi}, {32'd0, vecs[i].e_pc_imm});
      chk($sformatf("v%0d_stall_fi", i), {63'd0, stall_fi}, {63'd0, vecs[i].e_stall});
      chk($sformatf("v%0d_stall_do", i), {63'd0, stall_do}, {63'd0, vecs[i].e_stall});
      chk($sformatf("v%0d_flush", i), {63'd0, flush_fi}, {63'd0, vecs[i].e_flush});
      chk($sformatf("v%0d_bubble", i), {63'd0, bubble_eo}, {63'd0, vecs[i].e_bubble});
      chk($sformatf("v%0d_hold", i), {63'd0, hold_eo}, 0);
      perf_chk($sformatf("v%0d", i));
      if (vecs[i].e_stall) exp_perf++;
      tick();
      idle();
      #3;
      chk($sformatf("v%0d_nxt_flush", i), {63'd0, flush_fi}, {63'd0, vecs[i].e_nxt_flush});
      chk($sformatf("v%0d_nxt_pc_sel", i), {63'd0, pc_sel_fi}, 0);
      chk($sformatf("v%0d_nxt_stall", i), {63'd0, stall_fi}, 0);
      chk($sformatf("v%0d_nxt_hold", i), {63'd0, hold_eo}, 0);
      tick();
    end

    // REDIRECT ignores MUL/DIV start and load-use.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h40, 1'b0);
    tick();
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 32'h0, 1'b1);
    #3;
    chk("redir_flush", {63'd0, flush_fi}, 1);
    chk("redir_stall", {63'd0, stall_fi}, 0);
    chk("redir_bubble", {63'd0, bubble_eo}, 0);
    tick();
    idle();
    #3;
    chk("post_redir_hold", {63'd0, hold_eo}, 0);
    chk("post_redir_stall", {63'd0, stall_fi}, 0);
    tick();

    // MUL/DIV occupancy: start cycle plus 32 busy cycles, done on the 33rd.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1);
    #3;
    chk("md_start_stall", {63'd0, stall_fi}, 0);
    chk("md_start_hold", {63'd0, hold_eo}, 0);
    tick();
    for (int c = 1; c <= 32; c++) begin
      if (c == 10) drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 32'h200, 1'b1);
      else idle();
      #3;
      chk($sformatf("md%0d_stall_fi", c), {63'd0, stall_fi}, 1);
      chk($sformatf("md%0d_stall_do", c), {63'd0, stall_do}, 1);
      chk($sformatf("md%0d_hold", c), {63'd0, hold_eo}, 1);
      chk($sformatf("md%0d_pc_sel", c), {63'd0, pc_sel_fi}, 0);
      chk($sformatf("md%0d_flush", c), {63'd0, flush_fi}, 0);
      chk($sformatf("md%0d_bubble", c), {63'd0, bubble_eo}, 0);
      chk($sformatf("md%0d_done", c), {63'd0, muldiv_done_o}, 0);
      exp_perf++;
      tick();
    end
    idle();
    #3;
    chk("md_done", {63'd0, muldiv_done_o}, 1);
    chk("md_done_stall", {63'd0, stall_fi}, 0);
    chk("md_done_hold", {63'd0, hold_eo}, 0);
    perf_chk("md_end");
    tick();
    #3;
    chk("md_done_once", {63'd0, muldiv_done_o}, 0);
    tick();

    // Reset in the middle of MD_BUSY.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    idle();
    for (int c = 0; c < 5; c++) tick();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h300, 1'b0);
    Rst_Core_N = 1'b0;
    #1;
    chk("mrst_stall", {63'd0, stall_fi}, 0);
    chk("mrst_hold", {63'd0, hold_eo}, 0);
    chk("mrst_stall_do", {63'd0, stall_do}, 0);
    chk("mrst_pc_sel", {63'd0, pc_sel_fi}, 0);
    chk("mrst_pc_imm", {32'd0, pc_imm_fi}, 0);
    chk("mrst_flush", {63'd0, flush_fi}, 0);
    chk("mrst_done", {63'd0, muldiv_done_o}, 0);
    exp_perf = 0;
    perf_chk("mrst");
    tick();
    idle();
    Rst_Core_N = 1'b1;
    for (int c = 0; c < 36; c++) begin
      #3;
      chk($sformatf("prst%0d_hold", c), {63'd0, hold_eo}, 0);
      chk($sformatf("prst%0d_done", c), {63'd0, muldiv_done_o}, 0);
      tick();
    end
    perf_chk("prst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_hazard_ctrl.md
Name: fetch_hazard_ctrl

Overview:
- Pipeline control unit that sequences the fetch stage and the decode/execute boundary.
- Produces the fetch-stage controls (pc_sel_fi, pc_imm_fi, stall_fi, flush_fi) plus decode stall, execute bubble and execute hold.
- Resolves three hazard classes: load-use data hazards, taken branch/jump redirects, and multi-cycle MUL/DIV occupancy.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- DWIDTH, 32, address/data width of PC and branch target.
- MULDIV_LAT, 33, total execute-stage cycles of a MUL/DIV op; must be >= 2.
- PERF_W, 32, width of the stall-cycle counter.

Ports:
- Clk_Core  in  1  core clock.
- Rst_Core_N  in  1  reset, asynchronous, active-low.
- rs1_addr_di  in  5  rs1 index of the instruction in decode.
- rs2_addr_di  in  5  rs2 index of the instruction in decode.
- rs1_used_di  in  1  decode instruction reads rs1.
- rs2_used_di  in  1  decode instruction reads rs2.
- rd_addr_ei  in  5  rd index of the instruction in execute.
- mem_read_ei  in  1  execute instruction is a load.
- branch_taken_ei  in  1  execute resolved a taken branch/jump.
- branch_target_ei  in  DWIDTH  redirect target.
- muldiv_start_ei  in  1  MUL/DIV entered execute this cycle.
- pc_sel_fi  out  1  select pc_imm_fi as next PC.
- pc_imm_fi  out  DWIDTH  redirect target to fetch.
- stall_fi  out  1  hold PC and fetch output register.
- flush_fi  out  1  replace fetch output with NOP.
- stall_do  out  1  hold decode output register.
- bubble_eo  out  1  insert NOP into execute input.
- hold_eo  out  1  hold execute stage (MUL/DIV busy).
- muldiv_done_o  out  1  one-cycle pulse, MUL/DIV result valid.
- stall_cycles_o  out  PERF_W  saturating count of cycles with stall_fi=1.

Behaviour:
- Reset (async, Rst_Core_N low):
  - State goes to RUN; busy counter, perf counter and muldiv_done_o clear to 0.
  - All combinational outputs are forced to 0 while reset is low, pc_imm_fi included.
- States: RUN, REDIRECT, MD_BUSY. Registered: state, busy counter (width clog2(MULDIV_LAT)), perf counter, muldiv_done_o.
- Load-use hazard (combinational, RUN only), lu = mem_read_ei && rd_addr_ei != 0 && ((rs1_used_di && rs1_addr_di == rd_addr_ei) || (rs2_used_di && rs2_addr_di == rd_addr_ei)).
  - When lu: stall_fi = stall_do = bubble_eo = 1 in the same cycle.
  - Lasts one cycle and clears naturally once the load leaves execute. No state change.
- Redirect (RUN, branch_taken_ei = 1):
  - Same cycle: pc_sel_fi = 1, pc_imm_fi = branch_target_ei, flush_fi = 1, bubble_eo = 1; stall_fi = stall_do = 0.
  - Next state REDIRECT.
  - REDIRECT lasts exactly one cycle: flush_fi = 1 (kills the wrong-path instruction produced by the synchronous instruction read), all other controls 0, then RUN.
  - pc_imm_fi = 0 whenever pc_sel_fi = 0.
- MUL/DIV (RUN, muldiv_start_ei = 1, branch_taken_ei = 0):
  - Load counter with MULDIV_LAT-2; next state MD_BUSY.
  - In MD_BUSY: stall_fi = stall_do = hold_eo = 1, flush_fi = pc_sel_fi = bubble_eo = 0.
  - Counter decrements each cycle. When it is 0: next state RUN, muldiv_done_o registered to 1 for exactly one cycle.
  - Total execute occupancy is MULDIV_LAT cycles: the start cycle plus MULDIV_LAT-1 MD_BUSY cycles.
- Priority in RUN: branch_taken_ei > muldiv_start_ei > lu.
  - Lower-priority requests are ignored that cycle, with no effect on state or outputs.
- Inputs in REDIRECT and MD_BUSY: branch_taken_ei, muldiv_start_ei and lu are ignored.
- Perf counter: increments on every cycle where stall_fi = 1; saturates at all-ones and does not wrap.
- Reset mid-MD_BUSY: returns immediately to RUN; no muldiv_done_o pulse is generated.

Test Plan:
- Load-use: mem_read_ei=1, rd_addr_ei=5, rs1_addr_di=5, rs1_used_di=1 for one cycle -> stall_fi=stall_do=bubble_eo=1 that cycle only; stall_cycles_o goes 0->1.
- x0 and unused source: rd_addr_ei=0 with matching rs1; then rd_addr_ei=7, rs2_addr_di=7, rs2_used_di=0 -> no stall, no bubble in either case.
- Branch: branch_taken_ei=1, branch_target_ei=0x0000_0100 -> cycle N: pc_sel_fi=1, pc_imm_fi=0x100, flush_fi=1, bubble_eo=1; cycle N+1: flush_fi=1 only; cycle N+2: all controls 0.
- Priority: branch_taken_ei=1, muldiv_start_ei=1 and an lu match in the same cycle -> redirect behaviour only; no stall, no MD_BUSY entry.
- MUL/DIV, MULDIV_LAT=33: muldiv_start_ei pulse at cycle N -> stall_fi=hold_eo=1 for cycles N+1..N+32; muldiv_done_o=1 at cycle N+33 only; stall_cycles_o=32.
- Reset and saturation:
  - Assert Rst_Core_N low during MD_BUSY -> all outputs 0 immediately; after release state is RUN, no done pulse.
  - With PERF_W=4, run 20 stall cycles -> stall_cycles_o holds 0xF.
